// File: rtl/kamikaze_imem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
//   arb_state_e : arbiter FSM state encodings
//   owner_e     : which requester a memory transaction belongs to
//   cnt_width() : register width that can hold 0..max
package kamikaze_imem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WAIT_IF = 2'd1,
    ARB_WAIT_LS = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  function automatic int unsigned cnt_width(input int unsigned max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/kamikaze_starve_cnt.sv
// Saturating counter of consecutive load/store grants taken while a fetch
// was waiting.
//   clk_i / rst_i : clock, asynchronous active-low reset
//   inc           : count one more LS grant (holds at MAX)
//   clr           : return to zero (wins over inc)
//   full          : counter has reached MAX, fetch must be served next
module kamikaze_starve_cnt
  import kamikaze_imem_arbiter_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc,
  input  logic clr,
  output logic full
);

  localparam int unsigned CW = cnt_width(MAX);
  localparam logic [CW-1:0] MAX_V = CW'(MAX);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !full) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign full = (cnt == MAX_V);

endmodule

// File: rtl/kamikaze_imem_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and the
// load/store unit (LS), one transaction at a time. LS has priority unless IF
// has been passed over STARVE_MAX times in a row.
// Ports:
//   clk_i, rst_i                     : clock, asynchronous active-low reset
//   if_req_i/if_addr_i               : fetch request (held until if_gnt_o)
//   if_gnt_o/if_rvalid_o/if_rdata_o  : fetch accept / completion / data
//   ls_req_i/ls_we_i/ls_be_i/
//   ls_addr_i/ls_wdata_i             : LS request (held until ls_gnt_o)
//   ls_gnt_o/ls_rvalid_o/ls_rdata_o  : LS accept / completion / data
//   mem_req_o/we/be/addr/wdata       : request to memory, muxed from winner
//   mem_gnt_i/mem_rvalid_i/
//   mem_rdata_i                      : memory accept / completion / data
//   dbg_state                        : current arbiter state
// Handshake: a requester holds req and its fields until its gnt is seen high
// in a cycle; exactly one rvalid pulse follows later for that request, and
// the arbiter never accepts a new request in the cycle that rvalid returns.
module kamikaze_imem_arbiter
  import kamikaze_imem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [DATA_W/8-1:0] ls_be_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic [1:0]          dbg_state
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_e state;
  owner_e     sel;
  logic       sel_valid;
  logic       arb;
  logic       starve_full;
  logic       starve_inc;
  logic       starve_clr;

  // Outputs are combinational from inputs, so they are also forced low while
  // reset is asserted; otherwise a held request would leak through in IDLE.
  assign arb = rst_i && (state == ARB_IDLE);

  always_comb begin
    sel       = OWN_IF;
    sel_valid = 1'b0;
    if (ls_req_i && !(if_req_i && starve_full)) begin
      sel       = OWN_LS;
      sel_valid = 1'b1;
    end else if (if_req_i) begin
      sel       = OWN_IF;
      sel_valid = 1'b1;
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (arb && sel_valid) begin
      mem_req_o = 1'b1;
      if (sel == OWN_LS) begin
        mem_we_o    = ls_we_i;
        mem_be_o    = ls_be_i;
        mem_addr_o  = ls_addr_i;
        mem_wdata_o = ls_wdata_i;
      end else begin
        mem_be_o   = {BE_W{1'b1}};
        mem_addr_o = if_addr_i;
      end
    end
  end

  assign if_gnt_o = arb && sel_valid && (sel == OWN_IF) && mem_gnt_i;
  assign ls_gnt_o = arb && sel_valid && (sel == OWN_LS) && mem_gnt_i;

  assign if_rvalid_o = rst_i && (state == ARB_WAIT_IF) && mem_rvalid_i;
  assign ls_rvalid_o = rst_i && (state == ARB_WAIT_LS) && mem_rvalid_i;
  assign if_rdata_o  = rst_i ? mem_rdata_i : '0;
  assign ls_rdata_o  = rst_i ? mem_rdata_i : '0;

  assign dbg_state = state;

  // LS grants only count against IF while IF is actually waiting.
  assign starve_inc = ls_gnt_o && if_req_i;
  assign starve_clr = if_gnt_o || (ls_gnt_o && !if_req_i);

  kamikaze_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .full  (starve_full)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ARB_IDLE;
    end else begin
      case (state)
        ARB_IDLE: begin
          // A stray mem_rvalid_i here is simply not forwarded.
          if (ls_gnt_o)      state <= ARB_WAIT_LS;
          else if (if_gnt_o) state <= ARB_WAIT_IF;
        end
        ARB_WAIT_IF, ARB_WAIT_LS: begin
          if (mem_rvalid_i) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
